// File: rtl/network_mac_acc_5ns_16ns.sv
// rtl/network_mac_acc_5ns_16ns.sv - saturating multiply-accumulate with valid/ready framing
//
// Purpose: accumulates in_coef*in_data over a run of input beats terminated by
// in_last, then presents the sum, term count and a saturation flag as one result.
// Ports:
//   ap_clk, ap_rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready, in_coef, in_data,  input beat handshake and operands
//   in_last                               final term of the current sum
//   out_valid/out_ready                   result handshake
//   out_data, out_count, out_sat          sum, number of terms, saturation seen
module network_mac_acc_5ns_16ns #(
    parameter int ACC_WIDTH = 26,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_coef,
    input  logic [15:0]          in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
    logic                   out_sat_q, out_sat_d;

    logic [20:0]            product;
    logic [ACC_WIDTH:0]     acc_sum;
    logic                   acc_ovf;
    logic                   cnt_full;
    logic [ACC_WIDTH-1:0]   acc_new;
    logic [CNT_WIDTH-1:0]   cnt_new;
    logic                   sat_new;
    logic                   accept;

    // Full 21-bit product: both operands widened before the multiply.
    assign product  = {16'd0, in_coef} * {5'd0, in_data};

    // One extra bit on the adder; its carry is the saturation condition.
    assign acc_sum  = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - 21){1'b0}}, product};
    assign acc_ovf  = acc_sum[ACC_WIDTH];
    assign acc_new  = acc_ovf ? {ACC_WIDTH{1'b1}} : acc_sum[ACC_WIDTH-1:0];

    assign cnt_full = &cnt_q;
    assign cnt_new  = cnt_full ? cnt_q : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    assign sat_new  = sat_q | acc_ovf | cnt_full;

    assign out_valid = (state_q == ST_HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

    // acc/cnt/sat are always zero while in HOLD, so a beat accepted during the
    // drain cycle naturally starts a fresh sum from the adder above.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;

        if (state_q == ST_HOLD && out_ready) begin
            state_d = ST_ACCUM;
        end

        if (accept) begin
            if (in_last) begin
                out_data_d  = acc_new;
                out_count_d = cnt_new;
                out_sat_d   = sat_new;
                acc_d       = '0;
                cnt_d       = '0;
                sat_d       = 1'b0;
                state_d     = ST_HOLD;
            end else begin
                acc_d       = acc_new;
                cnt_d       = cnt_new;
                sat_d       = sat_new;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_network_mac_acc_5ns_16ns.sv
// tb/tb_network_mac_acc_5ns_16ns.sv - self-checking bench for network_mac_acc_5ns_16ns
module tb_network_mac_acc_5ns_16ns;

    localparam int W = 26;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_coef;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [W-1:0] out_data;
    logic [7:0]  out_count;
    logic        out_sat;

    logic        in_ready21;
    logic        out_valid21;
    logic [20:0] out_data21;
    logic [7:0]  out_count21;
    logic        out_sat21;

    int checks;
    int failures;

    // Reference model: terms summed as plain integers, result formed on the last term.
    bit          m_valid;
    logic [W-1:0] m_data;
    logic [7:0]  m_count;
    bit          m_sat;
    longint      m_sum;
    int          m_n;
    int          accepted_beats;

    network_mac_acc_5ns_16ns dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_coef  (in_coef),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_sat  (out_sat)
    );

    network_mac_acc_5ns_16ns #(.ACC_WIDTH(21), .CNT_WIDTH(8)) dut21 (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready21),
        .in_coef  (in_coef),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid21),
        .out_ready(out_ready),
        .out_data (out_data21),
        .out_count(out_count21),
        .out_sat  (out_sat21)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    task automatic model_reset();
        m_valid = 0;
        m_data  = '0;
        m_count = '0;
        m_sat   = 0;
        m_sum   = 0;
        m_n     = 0;
    endtask

    // Applies the current inputs to the model as the coming rising edge will.
    task automatic model_step();
        bit     rdy;
        longint maxv;
        maxv = (longint'(1) << W) - 1;
        rdy  = !m_valid || out_ready;
        if (m_valid && out_ready) m_valid = 0;
        if (in_valid && rdy) begin
            m_sum = m_sum + longint'(in_coef) * longint'(in_data);
            m_n   = m_n + 1;
            accepted_beats = accepted_beats + 1;
            if (in_last) begin
                m_data  = (m_sum > maxv) ? maxv[W-1:0] : m_sum[W-1:0];
                m_count = (m_n > 255) ? 8'd255 : m_n[7:0];
                m_sat   = (m_sum > maxv) || (m_n > 255);
                m_valid = 1;
                m_sum   = 0;
                m_n     = 0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] c, input logic [15:0] d,
                         input logic l, input logic r);
        in_valid  = v;
        in_coef   = c;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        model_step();
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_coef   = '0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_reset();
        @(negedge ap_clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count got=%0d exp=0", out_count); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        #2 ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        cycle(1, 5'd3, 16'd100, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_mid_valid got=%b exp=0", out_valid); end
        cycle(1, 5'd31, 16'd65535, 0, 1);
        cycle(1, 5'd1, 16'd1, 1, 1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 26'd2031886) begin failures++; $display("FAIL basic_data got=%0d exp=2031886", out_data); end
        checks++; if (out_data !== m_data) begin failures++; $display("FAIL basic_model_data got=%0d exp=%0d", out_data, m_data); end
        checks++; if (out_count !== 8'd3) begin failures++; $display("FAIL basic_count got=%0d exp=3", out_count); end
        checks++; if (out_sat !== 1'b0) begin failures++; $display("FAIL basic_sat got=%b exp=0", out_sat); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_coef   = 5'd7;
            in_data   = 16'd9;
            in_last   = 1'b1;
            out_ready = 1'b0;
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== 26'd2031886) begin failures++; $display("FAIL hold_data cyc=%0d got=%0d exp=2031886", i, out_data); end
            model_step();
            @(posedge ap_clk);
            @(negedge ap_clk);
        end
        checks++; if (out_count !== 8'd3) begin failures++; $display("FAIL hold_count got=%0d exp=3", out_count); end
        cycle(0, 5'd0, 16'd0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [3];
        logic [4:0]   cf [3];
        exp_d[0] = 26'd20; exp_d[1] = 26'd40; exp_d[2] = 26'd50;
        cf[0] = 5'd2; cf[1] = 5'd4; cf[2] = 5'd5;
        for (int i = 0; i < 3; i++) begin
            cycle(1, cf[i], 16'd10, 1, 1);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid idx=%0d got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== exp_d[i]) begin failures++; $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", i, out_data, exp_d[i]); end
            checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL b2b_count idx=%0d got=%0d exp=1", i, out_count); end
        end
        cycle(0, 5'd0, 16'd0, 0, 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_saturation();
        cycle(1, 5'd31, 16'd65535, 0, 1);
        cycle(1, 5'd31, 16'd65535, 0, 1);
        cycle(1, 5'd31, 16'd65535, 1, 1);
        checks++; if (out_data21 !== 21'd2097151) begin failures++; $display("FAIL sat21_data got=%0d exp=2097151", out_data21); end
        checks++; if (out_sat21 !== 1'b1) begin failures++; $display("FAIL sat21_flag got=%b exp=1", out_sat21); end
        checks++; if (out_count21 !== 8'd3) begin failures++; $display("FAIL sat21_count got=%0d exp=3", out_count21); end
        checks++; if (out_data !== m_data) begin failures++; $display("FAIL sat26_data got=%0d exp=%0d", out_data, m_data); end
        checks++; if (out_sat !== m_sat) begin failures++; $display("FAIL sat26_flag got=%b exp=%b", out_sat, m_sat); end
        cycle(1, 5'd1, 16'd1, 1, 1);
        checks++; if (out_sat21 !== 1'b0) begin failures++; $display("FAIL sat21_next_flag got=%b exp=0", out_sat21); end
        checks++; if (out_data21 !== 21'd1) begin failures++; $display("FAIL sat21_next_data got=%0d exp=1", out_data21); end
        cycle(0, 5'd0, 16'd0, 0, 1);
    endtask

    task automatic test_count_sat();
        int n;
        for (int s = 0; s < 2; s++) begin
            n = 255 + s;
            for (int i = 0; i < n; i++) cycle(1, 5'd0, 16'd1234, (i == n - 1), 1);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cnt_valid n=%0d got=%b exp=1", n, out_valid); end
            checks++; if (out_count !== 8'd255) begin failures++; $display("FAIL cnt_count n=%0d got=%0d exp=255", n, out_count); end
            checks++; if (out_sat !== m_sat) begin failures++; $display("FAIL cnt_sat n=%0d got=%b exp=%b", n, out_sat, m_sat); end
            checks++; if (out_data !== '0) begin failures++; $display("FAIL cnt_data n=%0d got=%0d exp=0", n, out_data); end
        end
        cycle(0, 5'd0, 16'd0, 0, 1);
    endtask

    task automatic test_reset_mid();
        cycle(1, 5'd9, 16'd11, 1, 1);
        cycle(1, 5'd5, 16'd5, 0, 1);
        cycle(1, 5'd5, 16'd5, 0, 1);
        in_valid = 1'b0;
        ap_rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL rstmid_data got=%0d exp=0", out_data); end
        checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", out_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        #3 ap_rst_n = 1'b1;
        model_reset();
        cycle(1, 5'd1, 16'd7, 1, 1);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_after_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 26'd7) begin failures++; $display("FAIL rstmid_after_data got=%0d exp=7", out_data); end
        checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=1", out_count); end
        cycle(0, 5'd0, 16'd0, 0, 1);
    endtask

    task automatic test_random();
        int cyc;
        cyc = 0;
        accepted_beats = 0;
        while (accepted_beats < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_coef   = 5'($urandom_range(0, 31));
            in_data   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(30000, 65535));
            in_last   = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            checks++; if (in_ready !== (!m_valid || out_ready)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (!m_valid || out_ready)); end
            checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid); end
            if (m_valid) begin
                checks++; if (out_data !== m_data) begin failures++; $display("FAIL rnd_data cyc=%0d got=%0d exp=%0d", cyc, out_data, m_data); end
                checks++; if (out_count !== m_count) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, out_count, m_count); end
                checks++; if (out_sat !== m_sat) begin failures++; $display("FAIL rnd_sat cyc=%0d got=%b exp=%b", cyc, out_sat, m_sat); end
            end
            model_step();
            @(posedge ap_clk);
            @(negedge ap_clk);
            cyc++;
        end
        checks++; if (accepted_beats < 10000) begin failures++; $display("FAIL rnd_budget beats=%0d exp=10000", accepted_beats); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        accepted_beats = 0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_saturation();
        test_count_sat();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
